// File: rtl/adc_vol_to_bcd.sv
// Block-averages raw ADC codes, scales the average to millivolts and converts the result
// to packed BCD with a sequential double-dabble.
module adc_vol_to_bcd #(
    parameter int unsigned VREF_MV  = 3300,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        sample_valid_i,
    input  logic [7:0]  sample_i,
    input  logic        clear_i,
    output logic        mv_valid_o,
    output logic [13:0] mv_o,
    output logic [15:0] bcd_o,
    output logic [7:0]  avg_code_o,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam int unsigned     AccW      = 8 + AVG_LOG2;
    localparam int unsigned     CntW      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned     Shift     = 8 + AVG_LOG2;
    localparam logic [CntW-1:0] CntLast   = CntW'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [31:0]     RoundBias = 32'd1 << (7 + AVG_LOG2);
    localparam logic [3:0]      LastIter  = 4'd13;

    typedef enum logic [1:0] {StIdle, StCalc, StConv, StDone} state_e;

    state_e          state_q;
    logic [AccW-1:0] acc_q, acc_d, sum;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            blk_done;

    logic [AccW-1:0] sum_q;
    logic [13:0]     mvbin_q;
    logic [7:0]      avgc_q;
    logic [29:0]     dd_q;
    logic [3:0]      iter_q;

    logic [13:0]     mv_calc;
    logic [7:0]      avg_calc;
    logic [15:0]     dd_adj;
    logic [29:0]     dd_next;
    logic            unused_dd_msb;

    function automatic logic [15:0] dd_adjust(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Accumulation runs independently of the conversion pipeline.
    always_comb begin
        sum      = acc_q + AccW'(sample_i);
        blk_done = sample_valid_i && !clear_i && (cnt_q == CntLast);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_valid_i) begin
            if (cnt_q == CntLast) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Round-half-up of avg * VREF / 256, done on the block sum.
    always_comb begin
        mv_calc       = 14'((32'(sum_q) * VREF_MV + RoundBias) >> Shift);
        avg_calc      = 8'(sum_q >> AVG_LOG2);
        dd_adj        = dd_adjust(dd_q[29:14]);
        dd_next       = {dd_adj[14:0], dd_q[13:0], 1'b0};
        unused_dd_msb = dd_adj[15];
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            sum_q      <= '0;
            mvbin_q    <= '0;
            avgc_q     <= '0;
            dd_q       <= '0;
            iter_q     <= '0;
            mv_valid_o <= 1'b0;
            mv_o       <= '0;
            bcd_o      <= '0;
            avg_code_o <= '0;
            overrun_o  <= 1'b0;
        end else begin
            mv_valid_o <= 1'b0;
            overrun_o  <= blk_done && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (blk_done) begin
                        sum_q   <= sum;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    mvbin_q <= mv_calc;
                    avgc_q  <= avg_calc;
                    dd_q    <= {16'h0000, mv_calc};
                    iter_q  <= '0;
                    state_q <= StConv;
                end
                StConv: begin
                    dd_q   <= dd_next;
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == LastIter) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    mv_o       <= mvbin_q;
                    bcd_o      <= dd_q[29:14];
                    avg_code_o <= avgc_q;
                    mv_valid_o <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_adc_vol_to_bcd.sv
// Scoreboard bench for adc_vol_to_bcd: default, AVG_LOG2=0 and VREF=5000/AVG_LOG2=4 instances.
module tb_adc_vol_to_bcd;

    logic sclk = 1'b0;
    logic nrst = 1'b0;
    always #5 sclk = ~sclk;

    logic [7:0] sample = 8'd0;
    logic       clear  = 1'b0;
    logic       vd = 1'b0, vz = 1'b0, vf = 1'b0;

    logic        mvv_d, busy_d, ovr_d, mvv_z, busy_z, ovr_z, mvv_f, busy_f, ovr_f;
    logic [13:0] mv_d, mv_z, mv_f;
    logic [15:0] bcd_d, bcd_z, bcd_f;
    logic [7:0]  avg_d, avg_z, avg_f;

    adc_vol_to_bcd u_d (
        .sclk(sclk), .nrst(nrst), .sample_valid_i(vd), .sample_i(sample), .clear_i(clear),
        .mv_valid_o(mvv_d), .mv_o(mv_d), .bcd_o(bcd_d), .avg_code_o(avg_d),
        .busy_o(busy_d), .overrun_o(ovr_d)
    );

    adc_vol_to_bcd #(.VREF_MV(3300), .AVG_LOG2(0)) u_z (
        .sclk(sclk), .nrst(nrst), .sample_valid_i(vz), .sample_i(sample), .clear_i(clear),
        .mv_valid_o(mvv_z), .mv_o(mv_z), .bcd_o(bcd_z), .avg_code_o(avg_z),
        .busy_o(busy_z), .overrun_o(ovr_z)
    );

    adc_vol_to_bcd #(.VREF_MV(5000), .AVG_LOG2(4)) u_f (
        .sclk(sclk), .nrst(nrst), .sample_valid_i(vf), .sample_i(sample), .clear_i(clear),
        .mv_valid_o(mvv_f), .mv_o(mv_f), .bcd_o(bcd_f), .avg_code_o(avg_f),
        .busy_o(busy_f), .overrun_o(ovr_f)
    );

    typedef struct {
        logic [13:0] mv;
        logic [15:0] bcd;
        logic [7:0]  avg;
    } exp_t;

    exp_t qd[$], qz[$], qf[$];
    int errors = 0, checks = 0;
    int pulses_d = 0, pulses_z = 0, pulses_f = 0;

    // Reference model: integer rounding and decimal digits via div/mod.
    function automatic exp_t model(input int sum, input int vref, input int l);
        int   mv;
        exp_t e;
        mv    = (sum * vref + (1 << (7 + l))) >> (8 + l);
        e.mv  = 14'(mv);
        e.bcd = {4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
        e.avg = 8'(sum >> l);
        return e;
    endfunction

    always @(negedge sclk) begin
        if (nrst && mvv_d) begin
            exp_t e;
            pulses_d++;
            checks++;
            if (qd.size() == 0) begin
                errors++;
                $display("FAIL sb_d unexpected mv_valid mv=%0d", mv_d);
            end else begin
                e = qd.pop_front();
                if (mv_d !== e.mv || bcd_d !== e.bcd || avg_d !== e.avg) begin
                    errors++;
                    $display("FAIL sb_d got mv=%0d bcd=%h avg=%0d expected mv=%0d bcd=%h avg=%0d",
                             mv_d, bcd_d, avg_d, e.mv, e.bcd, e.avg);
                end
            end
        end
    end

    always @(negedge sclk) begin
        if (nrst && mvv_z) begin
            exp_t e;
            pulses_z++;
            checks++;
            if (qz.size() == 0) begin
                errors++;
                $display("FAIL sb_z unexpected mv_valid mv=%0d", mv_z);
            end else begin
                e = qz.pop_front();
                if (mv_z !== e.mv || bcd_z !== e.bcd || avg_z !== e.avg) begin
                    errors++;
                    $display("FAIL sb_z got mv=%0d bcd=%h avg=%0d expected mv=%0d bcd=%h avg=%0d",
                             mv_z, bcd_z, avg_z, e.mv, e.bcd, e.avg);
                end
            end
        end
    end

    always @(negedge sclk) begin
        if (nrst && mvv_f) begin
            exp_t e;
            pulses_f++;
            checks++;
            if (qf.size() == 0) begin
                errors++;
                $display("FAIL sb_f unexpected mv_valid mv=%0d", mv_f);
            end else begin
                e = qf.pop_front();
                if (mv_f !== e.mv || bcd_f !== e.bcd || avg_f !== e.avg) begin
                    errors++;
                    $display("FAIL sb_f got mv=%0d bcd=%h avg=%0d expected mv=%0d bcd=%h avg=%0d",
                             mv_f, bcd_f, avg_f, e.mv, e.bcd, e.avg);
                end
            end
        end
    end

    // Caller sits on a negedge; the sample is captured on the following posedge.
    task automatic send(input int which, input logic [7:0] v);
        sample = v;
        case (which)
            0:       vd = 1'b1;
            1:       vz = 1'b1;
            default: vf = 1'b1;
        endcase
        @(negedge sclk);
        vd = 1'b0;
        vz = 1'b0;
        vf = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        idle(3);
        checks++;
        if ({mvv_d, mv_d, bcd_d, avg_d, busy_d, ovr_d} !== 41'd0) begin
            errors++;
            $display("FAIL reset_d outputs got %h expected 0",
                     {mvv_d, mv_d, bcd_d, avg_d, busy_d, ovr_d});
        end
        checks++;
        if ({busy_z, busy_f, mvv_z, mvv_f} !== 4'd0) begin
            errors++;
            $display("FAIL reset_zf busy/valid got %b expected 0000",
                     {busy_z, busy_f, mvv_z, mvv_f});
        end
        nrst = 1'b1;
        idle(2);
    endtask

    task automatic test_latency();
        int p0;
        p0 = pulses_d;
        for (int i = 0; i < 3; i++) begin
            send(0, 8'd255);
            idle(99);
        end
        qd.push_back(model(1020, 3300, 2));
        send(0, 8'd255);
        idle(15);
        checks++;
        if (mvv_d !== 1'b0 || busy_d !== 1'b1) begin
            errors++;
            $display("FAIL latency_pre got valid=%b busy=%b expected valid=0 busy=1", mvv_d, busy_d);
        end
        idle(1);
        checks++;
        if (mvv_d !== 1'b1 || busy_d !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge16 got valid=%b busy=%b expected valid=1 busy=0",
                     mvv_d, busy_d);
        end
        idle(30);
        checks++;
        if (pulses_d !== p0 + 1) begin
            errors++;
            $display("FAIL latency_pulses got %0d expected %0d", pulses_d - p0, 1);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] blk [3][4];
        blk[0] = '{8'd100, 8'd101, 8'd102, 8'd103};
        blk[1] = '{8'd128, 8'd128, 8'd128, 8'd128};
        blk[2] = '{8'd0, 8'd0, 8'd0, 8'd0};
        for (int b = 0; b < 3; b++) begin
            int s;
            s = 0;
            for (int i = 0; i < 4; i++) s += int'(blk[b][i]);
            qd.push_back(model(s, 3300, 2));
            for (int i = 0; i < 4; i++) send(0, blk[b][i]);
            idle(30);
        end
        checks++;
        if (qd.size() !== 0) begin
            errors++;
            $display("FAIL patterns_drain got %0d pending expected 0", qd.size());
        end
    endtask

    task automatic test_clear();
        send(0, 8'd200);
        send(0, 8'd200);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        qd.push_back(model(200, 3300, 2));
        for (int i = 0; i < 4; i++) send(0, 8'd50);
        idle(30);
        for (int i = 0; i < 3; i++) send(0, 8'd10);
        clear = 1'b1;
        send(0, 8'd255);
        clear = 1'b0;
        qd.push_back(model(160, 3300, 2));
        for (int i = 0; i < 4; i++) send(0, 8'd40);
        idle(30);
        checks++;
        if (qd.size() !== 0) begin
            errors++;
            $display("FAIL clear_drain got %0d pending expected 0", qd.size());
        end
    endtask

    task automatic test_back_to_back();
        qd.push_back(model(512, 3300, 2));
        qd.push_back(model(256, 3300, 2));
        for (int i = 0; i < 4; i++) send(0, 8'd128);
        for (int i = 0; i < 3; i++) send(0, 8'd64);
        idle(13);
        checks++;
        if (mvv_d !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_valid got %b expected 1", mvv_d);
        end
        send(0, 8'd64);
        checks++;
        if (ovr_d !== 1'b0 || busy_d !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got overrun=%b busy=%b expected overrun=0 busy=1",
                     ovr_d, busy_d);
        end
        idle(30);
        checks++;
        if (qd.size() !== 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d pending expected 0", qd.size());
        end
    endtask

    task automatic test_overrun();
        int p0;
        p0 = pulses_z;
        qz.push_back(model(255, 3300, 0));
        sample = 8'd255;
        vz = 1'b1;
        idle(1);
        sample = 8'd0;
        idle(1);
        vz = 1'b0;
        checks++;
        if (ovr_z !== 1'b1 || busy_z !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag got overrun=%b busy=%b expected overrun=1 busy=1",
                     ovr_z, busy_z);
        end
        idle(15);
        checks++;
        if (mvv_z !== 1'b1) begin
            errors++;
            $display("FAIL overrun_first_valid got %b expected 1", mvv_z);
        end
        qz.push_back(model(100, 3300, 0));
        send(1, 8'd100);
        checks++;
        if (ovr_z !== 1'b0 || busy_z !== 1'b1) begin
            errors++;
            $display("FAIL overrun_later_accept got overrun=%b busy=%b expected overrun=0 busy=1",
                     ovr_z, busy_z);
        end
        idle(30);
        checks++;
        if (pulses_z !== p0 + 2 || qz.size() !== 0) begin
            errors++;
            $display("FAIL overrun_pulses got %0d pending=%0d expected 2 pending=0",
                     pulses_z - p0, qz.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send(0, 8'd255);
        idle(7);
        @(posedge sclk);
        nrst = 1'b0;
        #1;
        checks++;
        if ({mvv_d, mv_d, bcd_d, avg_d, busy_d, ovr_d} !== 41'd0) begin
            errors++;
            $display("FAIL reset_mid outputs got %h expected 0",
                     {mvv_d, mv_d, bcd_d, avg_d, busy_d, ovr_d});
        end
        @(negedge sclk);
        nrst = 1'b1;
        idle(40);
        qd.push_back(model(1020, 3300, 2));
        for (int i = 0; i < 4; i++) send(0, 8'd255);
        idle(30);
        checks++;
        if (qd.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid_drain got %0d pending expected 0", qd.size());
        end
    endtask

    task automatic test_vref5000();
        int p0;
        p0 = pulses_f;
        qf.push_back(model(4080, 5000, 4));
        for (int i = 0; i < 16; i++) send(2, 8'd255);
        idle(30);
        checks++;
        if (pulses_f !== p0 + 1 || qf.size() !== 0) begin
            errors++;
            $display("FAIL vref5000 got pulses=%0d pending=%0d expected pulses=1 pending=0",
                     pulses_f - p0, qf.size());
        end
    endtask

    initial begin
        @(negedge sclk);
        test_reset();
        test_latency();
        test_patterns();
        test_clear();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_vref5000();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_vol_to_bcd.md
Name: adc_vol_to_bcd

Overview:
- Downstream consumer of the ADC081C021 I2C read block.
- Accepts each 8-bit raw code, qualified by that block's read_done pulse, and block-averages 2^AVG_LOG2 samples.
- Scales the average to millivolts using the supply/reference voltage, then converts it to 4 packed BCD digits with a sequential double-dabble.
- Output feeds the seven-segment display driver and the UART report logic.

Parameters:
- VREF_MV, 3300, ADC reference (VA supply) in mV; legal range 1..9999.
- AVG_LOG2, 2, log2 of samples per averaged block; legal range 0..4 (AVG_LOG2=0 converts every sample).

Ports:
- sclk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle pulse; sample is valid (connect to read_done).
- sample  in  8  raw ADC code (connect to voltage).
- clear  in  1  synchronous pulse; discards the partial accumulation.
- mv_valid  out  1  one-cycle pulse; mv, bcd and avg_code are updated.
- mv  out  14  averaged voltage in mV, binary.
- bcd  out  16  mv as packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- avg_code  out  8  averaged raw code, equal to sum >> AVG_LOG2 (truncated).
- busy  out  1  high while the scaling/BCD pipeline is not in IDLE.
- overrun  out  1  one-cycle pulse; a completed block was dropped because the pipeline was busy.

Behaviour:
- Reset (nrst=0, asynchronous):
  - mv_valid=0, mv=0, bcd=16'h0000, avg_code=0, busy=0, overrun=0.
  - Accumulator, sample counter and state cleared; state=IDLE.
- Accumulator:
  - Width is 8+AVG_LOG2 bits; sample counter is AVG_LOG2 bits and wraps naturally.
  - Each sample_valid adds sample to the accumulator and increments the counter.
  - The sample that completes a block (counter = 2^AVG_LOG2-1) forms sum = acc+sample. The accumulator and counter clear on that same edge.
  - Accumulation keeps running independently of the conversion pipeline.
- clear:
  - Zeroes the accumulator and counter on the next edge.
  - Has priority over a simultaneous sample_valid; that sample is dropped.
  - Does not abort a conversion in progress.
- Block completion (edge E0):
  - If state=IDLE: sum is latched into the conversion register and the state goes to CALC.
  - If state≠IDLE: sum is discarded, overrun=1 for one cycle, and the in-flight conversion continues unaffected.
- Pipeline states:
  - IDLE: waits for block completion.
  - CALC (edge E1):
    - mv_bin = (sum*VREF_MV + 2^(7+AVG_LOG2)) >> (8+AVG_LOG2), i.e. round-half-up of avg*VREF/256. Result fits 14 bits for every legal parameter.
    - avg_code_reg = sum >> AVG_LOG2.
    - Loads the BCD shift register with mv_bin and zero digits; iteration counter = 0.
    - Next state CONV.
  - CONV (edges E2..E15):
    - 14 iterations. Each iteration adds 3 to every BCD digit ≥5, then left-shifts the combined {bcd,bin} register by 1.
    - After the 14th iteration the next state is DONE.
  - DONE (edge E16):
    - Registers mv=mv_bin, bcd=digits, avg_code=avg_code_reg, and pulses mv_valid=1 for one cycle.
    - Next state IDLE.
- Timing:
  - Latency: mv_valid is high in the cycle following E16, i.e. 16 edges after the edge that captured the completing sample.
  - busy is high from E0 until the E16 edge (inclusive of the DONE state cycle) and low in the mv_valid cycle.
  - Back-to-back: a block completing in the same cycle as mv_valid (state IDLE) is accepted.
- Outputs hold their last values between mv_valid pulses.
- Reset mid-conversion: pipeline aborts, no mv_valid is emitted, and all outputs return to their reset values.

Test Plan:
- Defaults; four samples of 255 spaced 100 cycles apart → mv_valid 16 edges after the 4th pulse, mv=3287, bcd=16'h3287, avg_code=255, exactly one pulse.
- Four samples 100,101,102,103 → mv=1308, bcd=16'h1308, avg_code=101; four samples of 128 → mv=1650, bcd=16'h1650; four samples of 0 → mv=0, bcd=16'h0000.
- Two samples of 200, then clear, then four samples of 50 → single result mv=645 (200*3300/1024 path proves nothing leaked), avg_code=50; clear coincident with sample_valid → that sample is not counted.
- AVG_LOG2=0, samples on consecutive cycles → first accepted, second block gets overrun=1 and no extra mv_valid; a sample 16 cycles later is accepted.
- Drive nrst low at E8 of a conversion → all outputs 0 immediately; after release, four samples of 255 → mv=3287 normally.
- VREF_MV=5000, AVG_LOG2=4, sixteen samples of 255 → mv=4980, bcd=16'h4980.
